// File: rtl/enc_bin2onehot_pipe.sv
// Registered binary-to-one-hot / thermometer encoder with valid/ready on both
// sides, a 2-entry skid buffer, per-beat range flag and saturating error count.
module enc_bin2onehot_pipe #(
  parameter int unsigned IN_W      = 4,
  parameter int unsigned OUT_W     = 15,
  parameter int unsigned THERMO    = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_err
);

  if ((OUT_W > (32'd1 << IN_W)) || (OUT_W < 2)) begin : g_param_guard
    $fatal(1, "enc_bin2onehot_pipe: OUT_W must lie in 2..2**IN_W");
  end

  logic [OUT_W-1:0]     w_vec;
  logic                 w_err;
  logic                 w_accept;
  logic                 w_main_free;

  logic [OUT_W-1:0]     r_main_vec;
  logic                 r_main_err;
  logic                 r_main_valid;
  logic [OUT_W-1:0]     r_skid_vec;
  logic                 r_skid_err;
  logic                 r_skid_valid;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_comb begin
    w_err = (32'(in) >= OUT_W);
    w_vec = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (!w_err) begin
        w_vec[i] = (THERMO != 0) ? (i <= 32'(in)) : (i == 32'(in));
      end
    end
  end

  // in_ready comes straight from the skid flag, so no out_ready->in_ready path.
  assign in_ready    = !r_skid_valid;
  assign w_accept    = in_valid && !r_skid_valid;
  assign w_main_free = !r_main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vec   <= '0;
      r_main_err   <= 1'b0;
      r_main_valid <= 1'b0;
      r_skid_vec   <= '0;
      r_skid_err   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_vec   <= r_skid_vec;
        r_main_err   <= r_skid_err;
        r_main_valid <= 1'b1;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid_vec <= w_vec;
          r_skid_err <= w_err;
        end
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main_vec <= w_vec;
          r_main_err <= w_err;
        end
      end
    end else if (w_accept) begin
      r_skid_vec   <= w_vec;
      r_skid_err   <= w_err;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = r_main_valid;
  assign out       = r_main_vec;
  assign out_err   = r_main_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Scoreboard bench: three encoder configurations share one stimulus stream;
// each has its own expected-beat queue and error-count model.
module tb_enc_bin2onehot_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [3:0]  code = '0;

  logic        rdy0, rdy1, rdy2;
  logic        v0, v1, v2;
  logic [14:0] o0;
  logic [7:0]  o1;
  logic [14:0] o2;
  logic        e0, e1, e2;
  logic [7:0]  c0;
  logic [1:0]  c1, c2;

  always #5 clk = ~clk;

  enc_bin2onehot_pipe u_dflt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in(code),
    .out_valid(v0), .out_ready(out_ready), .out(o0), .out_err(e0),
    .err_cnt(c0), .clr_err(clr_err)
  );

  enc_bin2onehot_pipe #(.IN_W(3), .OUT_W(8), .THERMO(1), .ERR_CNT_W(2)) u_th (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in(code[2:0]),
    .out_valid(v1), .out_ready(out_ready), .out(o1), .out_err(e1),
    .err_cnt(c1), .clr_err(clr_err)
  );

  enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .THERMO(0), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in(code),
    .out_valid(v2), .out_ready(out_ready), .out(o2), .out_err(e2),
    .err_cnt(c2), .clr_err(clr_err)
  );

  int compared   = 0;
  int mismatched = 0;
  int n_acc      = 0;
  int m_cnt [3]  = '{0, 0, 0};

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic f_valid(input int k);
    return (k == 0) ? v0 : (k == 1) ? v1 : v2;
  endfunction
  function automatic logic f_ready(input int k);
    return (k == 0) ? rdy0 : (k == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic f_err(input int k);
    return (k == 0) ? e0 : (k == 1) ? e1 : e2;
  endfunction
  function automatic logic [15:0] f_out(input int k);
    return (k == 0) ? {1'b0, o0} : (k == 1) ? {8'h00, o1} : {1'b0, o2};
  endfunction
  function automatic logic [7:0] f_cnt(input int k);
    return (k == 0) ? c0 : (k == 1) ? {6'b0, c1} : {6'b0, c2};
  endfunction

  // Reference: one-hot is 2**code, thermometer is 2**(code+1)-1, out of range is {err,0}.
  function automatic logic [16:0] ref_enc(input int k, input logic [3:0] c);
    int cc;
    int w;
    cc = (k == 1) ? int'(c & 4'h7) : int'(c);
    w  = (k == 1) ? 8 : 15;
    if (cc >= w) return {1'b1, 16'h0000};
    if (k == 1) return {1'b0, 16'((1 << (cc + 1)) - 1)};
    return {1'b0, 16'(1 << cc)};
  endfunction

  task automatic q_push(input int k, input logic [16:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int k, output logic [16:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (k)
      0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
  endfunction

  // Called at posedge+1: drives inputs, predicts acceptance, advances one edge.
  task automatic step(input bit v, input logic [3:0] c, input bit ordy,
                      input bit clr, input bit r);
    int nx [3];
    logic [16:0] e;
    in_valid  = v;
    code      = c;
    out_ready = ordy;
    clr_err   = clr;
    rst       = r;
    for (int k = 0; k < 3; k++) begin
      nx[k] = m_cnt[k];
      e = ref_enc(k, c);
      if (r || clr) begin
        nx[k] = 0;
      end
      if (!r && v && f_ready(k)) begin
        q_push(k, e);
        if (k == 0) n_acc++;
        if (!clr && e[16] && (m_cnt[k] < ((k == 0) ? 255 : 3))) nx[k] = m_cnt[k] + 1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) m_cnt[k] = nx[k];
    if (r) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  // Monitor: pops on every output transfer and checks hold stability under stall.
  bit          held [3] = '{0, 0, 0};
  logic [15:0] hv   [3];
  logic        he   [3];

  always @(negedge clk) begin
    logic [16:0] e;
    bit ok;
    if (rst) begin
      for (int k = 0; k < 3; k++) held[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("err_cnt", 32'(f_cnt(k)), m_cnt[k]);
        if (held[k]) begin
          chk("stall_valid", 32'(f_valid(k)), 1);
          chk("stall_out", 32'(f_out(k)), 32'(hv[k]));
          chk("stall_err", 32'(f_err(k)), 32'(he[k]));
        end
        if (f_valid(k) && out_ready) begin
          q_pop(k, e, ok);
          if (!ok) begin
            chk("unexpected_beat", 32'(f_out(k)), 32'hFFFF_FFFF);
          end else begin
            chk("beat_out", 32'(f_out(k)), 32'(e[15:0]));
            chk("beat_err", 32'(f_err(k)), 32'(e[16]));
          end
        end
        held[k] = f_valid(k) && !out_ready;
        hv[k]   = f_out(k);
        he[k]   = f_err(k);
      end
    end
  end

  logic [15:0] exp_stream [4] = '{16'h0001, 16'h0002, 16'h4000, 16'h0000};
  logic [3:0]  stream_cd  [4] = '{4'd0, 4'd1, 4'd14, 4'd15};
  logic [7:0]  exp_th     [3] = '{8'h01, 8'h0F, 8'hFF};
  logic [3:0]  th_cd      [3] = '{4'd0, 4'd3, 4'd7};
  int          exp_sat    [5] = '{1, 2, 3, 3, 3};

  initial begin
    int cycles;
    @(posedge clk);
    #1;
    step(0, 4'd0, 1, 0, 1);
    step(0, 4'd0, 1, 0, 1);
    rst = 1'b0;
    chk("rst_out_valid", 32'(v0), 0);
    chk("rst_in_ready", 32'(rdy0), 1);
    chk("rst_out", 32'(o0), 0);
    chk("rst_out_err", 32'(e0), 0);
    chk("rst_err_cnt", 32'(c0), 0);

    for (int i = 0; i < 4; i++) begin
      step(1, stream_cd[i], 1, 0, 0);
      chk("stream_valid", 32'(v0), 1);
      chk("stream_out", 32'(o0), 32'(exp_stream[i]));
      chk("stream_err", 32'(e0), (i == 3) ? 1 : 0);
    end
    chk("stream_err_cnt", 32'(c0), 1);
    step(0, 4'd0, 1, 0, 0);

    step(1, 4'd3, 0, 0, 0);
    chk("bp_ready_1", 32'(rdy0), 1);
    step(1, 4'd5, 0, 0, 0);
    chk("bp_ready_2", 32'(rdy0), 0);
    step(1, 4'd7, 0, 0, 0);
    chk("bp_hold_out", 32'(o0), 32'h0008);
    chk("bp_ready_3", 32'(rdy0), 0);
    step(1, 4'd7, 1, 0, 0);
    chk("bp_drain_1", 32'({v0, o0}), 32'({1'b1, 15'h0020}));
    step(1, 4'd7, 1, 0, 0);
    chk("bp_drain_2", 32'({v0, o0}), 32'({1'b1, 15'h0080}));
    step(0, 4'd0, 1, 0, 0);

    for (int i = 0; i < 3; i++) begin
      step(1, th_cd[i], 1, 0, 0);
      chk("thermo_out", 32'(o1), 32'(exp_th[i]));
      chk("thermo_err", 32'(e1), 0);
    end
    step(0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'd15, 1, 0, 0);
      chk("sat_cnt", 32'(c2), exp_sat[i]);
    end
    step(1, 4'd15, 1, 1, 0);
    chk("clr_priority", 32'(c2), 0);
    step(0, 4'd0, 1, 0, 0);

    step(1, 4'd2, 0, 0, 0);
    step(1, 4'd4, 0, 0, 0);
    step(1, 4'd6, 0, 0, 0);
    step(1, 4'd9, 0, 0, 1);
    rst = 1'b0;
    chk("mrst_out_valid", 32'(v0), 0);
    chk("mrst_in_ready", 32'(rdy0), 1);
    chk("mrst_err_cnt", 32'(c0), 0);
    for (int i = 0; i < 3; i++) step(0, 4'd0, 1, 0, 0);
    chk("mrst_no_stale", 32'(v0), 0);

    n_acc  = 0;
    cycles = 0;
    while (n_acc < 10000 && cycles < 60000) begin
      step(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), 0);
      cycles++;
    end
    if (n_acc < 10000) chk("random_budget", n_acc, 10000);

    for (int i = 0; i < 4; i++) step(0, 4'd0, 1, 0, 0);
    for (int k = 0; k < 3; k++) chk("drain_queue", q_size(k), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
